// File: rtl/core_pkg.sv
// Shared core package: memory sizes, funct3 memory codes,
// arbiter state and grant encodings.
package core_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUS  = 3'b010,
    RESP = 3'b100
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/core_lane_align.sv
// Byte-lane steering: sel, write replication, misalign
// detection and load extraction with zero/sign extension.
module core_lane_align
  import core_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdat,
  output logic        misalign,
  output logic [31:0] ldata
);

  logic [31:0] sh;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    sel      = 4'b0000;
    wdat     = 32'h0;
    misalign = 1'b1;
    ldata    = 32'h0;
    unique case (size)
      BYTE: begin
        sel      = 4'b0001 << off;
        wdat     = {4{wdata[7:0]}};
        misalign = 1'b0;
        ldata    = {{24{sgn & sh[7]}}, sh[7:0]};
      end
      HALF: begin
        sel      = 4'b0011 << {off[1], 1'b0};
        wdat     = {2{wdata[15:0]}};
        misalign = off[0];
        ldata    = {{16{sgn & sh[15]}}, sh[15:0]};
      end
      WORD: begin
        sel      = 4'b1111;
        wdat     = wdata;
        misalign = |off;
        ldata    = rdata;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one Wishbone classic master between instruction
// fetch and load/store, with lane steering and bus timeout.
module core_mem_arbiter
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          DATA_PRIORITY  = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        fetch_req_in,
  input  logic [31:0] fetch_addr_in,
  output logic        fetch_done_out,
  output logic        fetch_err_out,
  output logic [31:0] fetch_data_out,
  input  logic        data_req_in,
  input  logic        data_we_in,
  input  logic [31:0] data_addr_in,
  input  logic [1:0]  data_size_in,
  input  logic        data_signed_in,
  input  logic [31:0] data_wdata_in,
  output logic        data_done_out,
  output logic        data_err_out,
  output logic [31:0] data_rdata_out,
  output logic        wb_cyc_out,
  output logic        wb_stb_out,
  output logic        wb_we_out,
  output logic [31:0] wb_adr_out,
  output logic [3:0]  wb_sel_out,
  output logic [31:0] wb_dat_out,
  input  logic [31:0] wb_dat_in,
  input  logic        wb_ack_in,
  input  logic        wb_err_in
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  arb_state_t  state;
  grant_t      gnt;
  logic [31:0] adr_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic        we_q;
  logic [31:0] wdat_q;
  logic [31:0] cnt;
  logic        err_q;
  logic [31:0] fdata_q;
  logic [31:0] rdata_q;

  logic        idle;
  logic        bus;
  logic        resp;
  logic        any_req;
  logic        pick_data;

  logic [31:0] in_adr;
  logic [1:0]  in_size;
  logic        in_sgn;
  logic        in_we;
  logic [31:0] in_wdat;

  logic [3:0]  sel;
  logic [31:0] wdat;
  logic        mis;
  logic [31:0] ldata;

  assign idle = (state == IDLE);
  assign bus  = (state == BUS);
  assign resp = (state == RESP);

  assign any_req   = fetch_req_in | data_req_in;
  assign pick_data = data_req_in & (DATA_PRIORITY | ~fetch_req_in);

  always_comb begin
    if (pick_data) begin
      in_adr  = data_addr_in;
      in_size = data_size_in;
      in_sgn  = data_signed_in;
      in_we   = data_we_in;
      in_wdat = data_wdata_in;
    end else begin
      in_adr  = fetch_addr_in;
      in_size = WORD;
      in_sgn  = 1'b0;
      in_we   = 1'b0;
      in_wdat = 32'h0;
    end
  end

  // In IDLE the aligner judges the incoming winner; afterwards it
  // works on the latched transfer so bus signals stay stable.
  core_lane_align u_align (
    .off      (idle ? in_adr[1:0] : adr_q[1:0]),
    .size     (idle ? in_size : size_q),
    .sgn      (idle ? in_sgn : sgn_q),
    .wdata    (idle ? in_wdat : wdat_q),
    .rdata    (wb_dat_in),
    .sel      (sel),
    .wdat     (wdat),
    .misalign (mis),
    .ldata    (ldata)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state   <= IDLE;
      gnt     <= GRANT_FETCH;
      adr_q   <= 32'h0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      we_q    <= 1'b0;
      wdat_q  <= 32'h0;
      cnt     <= 32'h0;
      err_q   <= 1'b0;
      fdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt    <= pick_data ? GRANT_DATA : GRANT_FETCH;
            adr_q  <= in_adr;
            size_q <= in_size;
            sgn_q  <= in_sgn;
            we_q   <= in_we;
            wdat_q <= in_wdat;
            cnt    <= 32'h0;
            err_q  <= mis;
            state  <= mis ? RESP : BUS;
          end
        end
        BUS: begin
          if (wb_err_in) begin
            err_q <= 1'b1;
            state <= RESP;
          end else if (wb_ack_in) begin
            err_q <= 1'b0;
            state <= RESP;
            if (gnt == GRANT_FETCH) begin
              fdata_q <= ldata;
            end else if (!we_q) begin
              rdata_q <= ldata;
            end
          end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign wb_cyc_out = bus;
  assign wb_stb_out = bus;
  assign wb_we_out  = bus & we_q;
  assign wb_adr_out = bus ? {adr_q[31:2], 2'b00} : 32'h0;
  assign wb_sel_out = bus ? sel : 4'b0000;
  assign wb_dat_out = bus ? wdat : 32'h0;

  assign fetch_done_out = resp & (gnt == GRANT_FETCH);
  assign fetch_err_out  = fetch_done_out & err_q;
  assign fetch_data_out = fdata_q;
  assign data_done_out  = resp & (gnt == GRANT_DATA);
  assign data_err_out   = data_done_out & err_q;
  assign data_rdata_out = rdata_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed-vector bench for core_mem_arbiter: per-transfer table
// plus priority, timeout and reset sequences.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic        fetch_err;
  logic [31:0] fetch_data;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_signed;
  logic [31:0] data_wdata;
  logic        data_done;
  logic        data_err;
  logic [31:0] data_rdata;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        berr;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_f = 32'h0;
  logic [31:0] exp_d = 32'h0;

  always #5 clk = ~clk;

  core_mem_arbiter #(
    .TIMEOUT_CYCLES (4),
    .DATA_PRIORITY  (1'b1)
  ) dut (
    .clk_in         (clk),
    .reset_in       (rst_n),
    .fetch_req_in   (fetch_req),
    .fetch_addr_in  (fetch_addr),
    .fetch_done_out (fetch_done),
    .fetch_err_out  (fetch_err),
    .fetch_data_out (fetch_data),
    .data_req_in    (data_req),
    .data_we_in     (data_we),
    .data_addr_in   (data_addr),
    .data_size_in   (data_size),
    .data_signed_in (data_signed),
    .data_wdata_in  (data_wdata),
    .data_done_out  (data_done),
    .data_err_out   (data_err),
    .data_rdata_out (data_rdata),
    .wb_cyc_out     (cyc),
    .wb_stb_out     (stb),
    .wb_we_out      (we),
    .wb_adr_out     (adr),
    .wb_sel_out     (sel),
    .wb_dat_out     (dat_o),
    .wb_dat_in      (dat_i),
    .wb_ack_in      (ack),
    .wb_err_in      (berr)
  );

  typedef struct {
    logic        fetch;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rdat;
    int          waits;
    int          resp;
    int          exp_cyc;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdat;
    logic        exp_err;
    logic [31:0] exp_val;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".cyc"}, {31'h0, cyc}, 32'h0);
    chk({tag, ".stb"}, {31'h0, stb}, 32'h0);
    chk({tag, ".we"}, {31'h0, we}, 32'h0);
    chk({tag, ".adr"}, adr, 32'h0);
    chk({tag, ".sel"}, {28'h0, sel}, 32'h0);
    chk({tag, ".dat"}, dat_o, 32'h0);
    chk({tag, ".fdata"}, fetch_data, 32'h0);
    chk({tag, ".rdata"}, data_rdata, 32'h0);
    chk({tag, ".done"},
        {28'h0, fetch_done, fetch_err, data_done, data_err}, 32'h0);
  endtask

  task automatic xfer(input int id, input vec_t v);
    int   cyc_n;
    int   done_at;
    logic seen;
    logic got_err;
    logic other;
    string t;
    t = $sformatf("v%0d", id);
    cyc_n = 0;
    done_at = 0;
    seen = 1'b0;
    got_err = 1'b0;
    other = 1'b0;
    @(negedge clk);
    if (v.fetch) begin
      fetch_req  = 1'b1;
      fetch_addr = v.addr;
    end else begin
      data_req    = 1'b1;
      data_we     = v.wr;
      data_addr   = v.addr;
      data_size   = v.size;
      data_signed = v.sgn;
      data_wdata  = v.wdata;
    end
    for (int i = 1; i <= 12 && done_at == 0; i++) begin
      @(negedge clk);
      ack = 1'b0;
      berr = 1'b0;
      dat_i = 32'h0;
      if (cyc) begin
        if (!seen) begin
          seen = 1'b1;
          chk({t, ".sel"}, {28'h0, sel}, {28'h0, v.exp_sel});
          chk({t, ".we"}, {31'h0, we}, {31'h0, v.wr});
          chk({t, ".adr"}, adr, {v.addr[31:2], 2'b00});
          chk({t, ".wdat"}, dat_o, v.exp_wdat);
        end
        cyc_n++;
        if (cyc_n > v.waits) begin
          case (v.resp)
            0: begin ack = 1'b1; dat_i = v.rdat; end
            1: berr = 1'b1;
            2: begin ack = 1'b1; berr = 1'b1; dat_i = v.rdat; end
            default: ;
          endcase
        end
      end
      if (fetch_done || data_done) begin
        done_at = i;
        got_err = v.fetch ? fetch_err : data_err;
        other = v.fetch ? data_done : fetch_done;
      end
    end
    if (!v.exp_err && !v.wr) begin
      if (v.fetch) exp_f = v.exp_val;
      else exp_d = v.exp_val;
    end
    chk({t, ".lat"}, done_at, v.exp_cyc + 1);
    chk({t, ".ncyc"}, cyc_n, v.exp_cyc);
    chk({t, ".err"}, {31'h0, got_err}, {31'h0, v.exp_err});
    chk({t, ".other"}, {31'h0, other}, 32'h0);
    chk({t, ".fdata"}, fetch_data, exp_f);
    if (!v.wr) chk({t, ".rdata"}, data_rdata, exp_d);
    fetch_req = 1'b0;
    data_req = 1'b0;
    ack = 1'b0;
    berr = 1'b0;
    dat_i = 32'h0;
  endtask

  initial begin
    int d_at;
    int f_at;
    int f_cyc;
    logic [31:0] first_adr;
    int n;
    logic spurious;
    vec_t rv;

    tv[0]  = '{1, 0, 32'h10,  2'b10, 0, 32'h0, 32'h00430313, 0, 0, 1,
               4'hF, 32'h0, 0, 32'h00430313};
    tv[1]  = '{0, 0, 32'h103, 2'b00, 1, 32'h0, 32'h80FFFF7F, 0, 0, 1,
               4'b1000, 32'h0, 0, 32'hFFFFFF80};
    tv[2]  = '{0, 0, 32'h103, 2'b00, 0, 32'h0, 32'h80FFFF7F, 0, 0, 1,
               4'b1000, 32'h0, 0, 32'h00000080};
    tv[3]  = '{0, 0, 32'h102, 2'b01, 1, 32'h0, 32'h80FFFF7F, 0, 0, 1,
               4'b1100, 32'h0, 0, 32'hFFFF80FF};
    tv[4]  = '{0, 0, 32'h102, 2'b01, 0, 32'h0, 32'h80FFFF7F, 0, 0, 1,
               4'b1100, 32'h0, 0, 32'h000080FF};
    tv[5]  = '{0, 0, 32'h100, 2'b10, 0, 32'h0, 32'hDEADBEEF, 2, 0, 3,
               4'hF, 32'h0, 0, 32'hDEADBEEF};
    tv[6]  = '{0, 1, 32'h201, 2'b00, 0, 32'hAB, 32'h0, 0, 0, 1,
               4'b0010, 32'hABABABAB, 0, 32'h0};
    tv[7]  = '{0, 1, 32'h203, 2'b01, 0, 32'h1234, 32'h0, 0, 3, 0,
               4'h0, 32'h0, 1, 32'h0};
    tv[8]  = '{0, 1, 32'h202, 2'b01, 0, 32'h1234ABCD, 32'h0, 0, 0, 1,
               4'b1100, 32'hABCDABCD, 0, 32'h0};
    tv[9]  = '{0, 1, 32'h204, 2'b10, 0, 32'h11223344, 32'h0, 1, 0, 2,
               4'hF, 32'h11223344, 0, 32'h0};
    tv[10] = '{0, 0, 32'h102, 2'b10, 0, 32'h0, 32'h0, 0, 3, 0,
               4'h0, 32'h0, 1, 32'h0};
    tv[11] = '{0, 0, 32'h100, 2'b11, 0, 32'h0, 32'h0, 0, 3, 0,
               4'h0, 32'h0, 1, 32'h0};
    tv[12] = '{1, 0, 32'h22,  2'b10, 0, 32'h0, 32'h0, 0, 3, 0,
               4'h0, 32'h0, 1, 32'h0};
    tv[13] = '{0, 0, 32'h300, 2'b10, 0, 32'h0, 32'h0, 0, 3, 4,
               4'hF, 32'h0, 1, 32'h0};
    tv[14] = '{0, 0, 32'h100, 2'b10, 0, 32'h0, 32'h55555555, 0, 2, 1,
               4'hF, 32'h0, 1, 32'h0};
    tv[15] = '{0, 0, 32'h100, 2'b10, 0, 32'h0, 32'h66666666, 1, 1, 2,
               4'hF, 32'h0, 1, 32'h0};
    tv[16] = '{0, 0, 32'h101, 2'b00, 1, 32'h0, 32'h00007F00, 0, 0, 1,
               4'b0010, 32'h0, 0, 32'h0000007F};
    tv[17] = '{1, 0, 32'h40,  2'b10, 0, 32'h0, 32'h12345678, 1, 0, 2,
               4'hF, 32'h0, 0, 32'h12345678};

    rst_n = 1'b0;
    fetch_req = 1'b0;
    fetch_addr = 32'h0;
    data_req = 1'b0;
    data_we = 1'b0;
    data_addr = 32'h0;
    data_size = 2'b00;
    data_signed = 1'b0;
    data_wdata = 32'h0;
    dat_i = 32'h0;
    ack = 1'b0;
    berr = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 18; k++) xfer(k, tv[k]);

    // Simultaneous requests: data wins, fetch follows after IDLE.
    @(negedge clk);
    fetch_req = 1'b1;
    fetch_addr = 32'h20;
    data_req = 1'b1;
    data_we = 1'b0;
    data_addr = 32'h100;
    data_size = 2'b10;
    data_signed = 1'b0;
    d_at = 0;
    f_at = 0;
    f_cyc = 0;
    first_adr = 32'hFFFFFFFF;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      ack = 1'b0;
      dat_i = 32'h0;
      if (cyc) begin
        if (first_adr == 32'hFFFFFFFF) first_adr = adr;
        if (adr == 32'h20 && f_cyc == 0) f_cyc = i;
        ack = 1'b1;
        dat_i = (adr == 32'h100) ? 32'hAAAA0001 : 32'hBBBB0002;
      end
      if (data_done && d_at == 0) begin
        d_at = i;
        data_req = 1'b0;
      end
      if (fetch_done && f_at == 0) begin
        f_at = i;
        fetch_req = 1'b0;
      end
    end
    ack = 1'b0;
    exp_d = 32'hAAAA0001;
    exp_f = 32'hBBBB0002;
    chk("prio.first", first_adr, 32'h100);
    chk("prio.dlat", d_at, 2);
    chk("prio.fcyc", f_cyc, 4);
    chk("prio.flat", f_at, 5);
    chk("prio.rdata", data_rdata, exp_d);
    chk("prio.fdata", fetch_data, exp_f);

    // Reset while the slave inserts wait states.
    @(negedge clk);
    data_req = 1'b1;
    data_we = 1'b0;
    data_addr = 32'h400;
    data_size = 2'b10;
    n = 0;
    for (int i = 1; i <= 10 && n < 2; i++) begin
      @(negedge clk);
      if (cyc) n++;
    end
    chk("rst.ncyc", n, 2);
    rst_n = 1'b0;
    data_req = 1'b0;
    @(negedge clk);
    chk_zero("rst.mid");
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (fetch_done || data_done || cyc) spurious = 1'b1;
    end
    chk("rst.quiet", {31'h0, spurious}, 32'h0);
    exp_f = 32'h0;
    exp_d = 32'h0;
    rv = '{0, 0, 32'h400, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0, 0, 1,
           4'hF, 32'h0, 0, 32'hCAFEF00D};
    xfer(99, rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
Memory access unit for the RV32 core. It shares a single Wishbone classic master port between the core's instruction-fetch path and its load/store path, with fixed priority. It also performs byte-lane steering for LB/LH/LW/LBU/LHU/SB/SH/SW, misalignment detection and bus timeout. It sits between the core FSM (FETCH/WAIT_FETCH and EXECUTE/WAIT_MEM states) and the SoC interconnect.

Parameters:
TIMEOUT_CYCLES, 255, number of bus-wait cycles before abort with error; 0 disables the timeout.
DATA_PRIORITY, 1, 1 = data port wins simultaneous requests; 0 = fetch port wins.

Ports:
clk_in  input  1  clock; all logic on posedge
reset_in  input  1  synchronous, active-low reset
fetch_req_in  input  1  fetch request (level); held until fetch_done_out
fetch_addr_in  input  32  fetch byte address
fetch_done_out  output  1  one-cycle completion pulse
fetch_err_out  output  1  valid with done: misaligned, bus error or timeout
fetch_data_out  output  32  fetched instruction; held until next fetch completion
data_req_in  input  1  load/store request (level); held until data_done_out
data_we_in  input  1  1 = store, 0 = load
data_addr_in  input  32  byte address
data_size_in  input  2  00 byte, 01 half, 10 word, 11 invalid (funct3[1:0])
data_signed_in  input  1  sign-extend load result (funct3[2]==0)
data_wdata_in  input  32  store data, right-aligned
data_done_out  output  1  one-cycle completion pulse
data_err_out  output  1  valid with done
data_rdata_out  output  32  aligned, extended load result; held until next data completion
wb_cyc_out  output  1  Wishbone CYC
wb_stb_out  output  1  Wishbone STB (equal to CYC)
wb_we_out  output  1  Wishbone WE
wb_adr_out  output  32  word address {addr[31:2],2'b00}
wb_sel_out  output  4  byte lane select
wb_dat_out  output  32  write data, lane-replicated
wb_dat_in  input  32  read data
wb_ack_in  input  1  acknowledge
wb_err_in  input  1  bus error

Behaviour:
- Reset (reset_in==0 at posedge): state IDLE; all outputs 0, including held data registers and timeout counter. Reset mid-cycle drops CYC/STB at that edge without completing the transfer; no done pulse is issued.
- FSM states:
  - IDLE: samples requests at each edge. Grant follows DATA_PRIORITY. The address, size, sign, we and wdata of the winner are latched. A legal request goes to BUS. A misaligned or invalid request goes to RESP with err=1 and no bus cycle.
  - BUS: CYC=STB=1; adr/sel/we/dat driven from the latched values, stable throughout. On ack or err (or timeout) at an edge, go to RESP. Read data is captured on ack.
  - RESP: exactly one cycle; done and err of the granted port are high. Requests are ignored in this cycle (requester drops req at the same edge), then return to IDLE.
- Latency: request sampled at edge k → CYC high from cycle k+1. If ack arrives in bus cycle m, done is high in cycle m+1. Zero-wait slave: 3 cycles from request to done. Back-to-back grants are at most once per 3 cycles.
- Misalignment:
  - Fetch: addr[1:0]!=0.
  - Half: addr[0]!=0.
  - Word: addr[1:0]!=0.
  - data_size_in==11 is invalid.
  - All of these give err=1, done in the cycle after grant, and CYC never asserted.
- sel generation:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<{addr[1],1'b0}.
  - Word: 4'b1111.
  - Fetch and loads use the same sel as the size.
- Write data: byte replicated ×4, half replicated ×2, word unchanged.
- Load data: wb_dat_in>>(8*addr[1:0]), then truncate to size and zero- or sign-extend per data_signed_in. Word loads are unchanged.
- Error/ack rules:
  - ack and err together → err wins; rdata is not updated.
  - On err, fetch_data_out/data_rdata_out keep their previous value.
  - ack/err outside BUS are ignored.
- Timeout: counter clears on entering BUS and increments each BUS cycle without ack/err. When it reaches TIMEOUT_CYCLES, CYC drops at that edge → RESP with err=1.
- The non-granted requester waits; its request stays pending and is served on the next IDLE.

Decomposition:
- Shared package core_pkg: mem_size_t (BYTE/HALF/WORD), funct3 memory constants, arb_state_t (IDLE/BUS/RESP as one-hot), grant_t (GRANT_FETCH/GRANT_DATA). The core later imports the same package.
- One combinational sub-module, core_lane_align: produces sel, replicated write data, misalign flag and the extracted/extended load result from addr[1:0], size and sign. It is reused by verification as a reference model.

Test Plan:
- Fetch addr 0x0000_0010, slave acks in first bus cycle with 0x00430313 → CYC high 1 cycle, sel=1111, fetch_done in cycle 3 with data 0x00430313, err=0.
- Simultaneous fetch (0x20) and load word (0x100), DATA_PRIORITY=1 → data served first; fetch CYC begins one cycle after data RESP.
- LB addr 0x103, wb_dat_in=0x80FF_FF7F → sel=1000, rdata=0xFFFF_FF80. LBU gives 0x0000_0080. LH addr 0x102 gives 0xFFFF_80FF.
- SB addr 0x201, wdata=0x0000_00AB → sel=0010, wb_dat_out=0xABAB_ABAB, we=1. SH addr 0x203 → err=1, no CYC.
- Slave never acks, TIMEOUT_CYCLES=4 → CYC high exactly 4 cycles, done with err=1. Slave asserts ack+err together → err=1, rdata unchanged.
- reset_in low during BUS with wait states → CYC=0 and all outputs 0 after that edge, no done pulse. A request re-issued after reset completes normally.
